// File: rtl/barrel_shift_sequencer.sv
// ============================================================================
//  Module      : barrel_shift_sequencer
//  Description : Two-requester logical-left shifter. One 8-bit barrel stage is
//                shared, and large shift amounts are applied over several passes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_shift_sequencer #(
  parameter int PASS_MAX = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic [3:0] req0_amt,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic [3:0] req1_amt,
  output logic       req1_ready,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       res_id,
  input  logic       res_ready,
  output logic       busy
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_shift = 2'd1;
  localparam logic [1:0] c_done  = 2'd2;

  localparam logic [3:0] c_pass_max = 4'(PASS_MAX);

  logic [1:0] r_state;
  logic       r_ptr;
  logic [7:0] r_work;
  logic [3:0] r_rem;
  logic       r_id;

  logic       w_idle;
  logic       w_grant0;
  logic       w_grant1;
  logic [7:0] w_acc_data;
  logic [3:0] w_acc_amt;
  logic [2:0] w_step;
  logic [3:0] w_rem_next;
  logic [7:0] w_s1;
  logic [7:0] w_s2;
  logic [7:0] w_s3;

  assign w_idle = (r_state == c_idle);

  // The pointer-favoured requester wins; the other wins only when it is alone.
  assign w_grant0 = w_idle & req0_valid & (~r_ptr | ~req1_valid);
  assign w_grant1 = w_idle & req1_valid & ( r_ptr | ~req0_valid);

  assign w_acc_data = w_grant1 ? req1_data : req0_data;
  assign w_acc_amt  = w_grant1 ? req1_amt  : req0_amt;

  assign w_step     = (r_rem > c_pass_max) ? c_pass_max[2:0] : r_rem[2:0];
  assign w_rem_next = r_rem - {1'b0, w_step};

  // Three-level log shifter, zero fill.
  assign w_s1 = w_step[0] ? {r_work[6:0], 1'b0}  : r_work;
  assign w_s2 = w_step[1] ? {w_s1[5:0], 2'b00}   : w_s1;
  assign w_s3 = w_step[2] ? {w_s2[3:0], 4'b0000} : w_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_idle;
      r_ptr   <= 1'b0;
      r_work  <= 8'h00;
      r_rem   <= 4'd0;
      r_id    <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_grant0 | w_grant1) begin
            r_work  <= w_acc_data;
            r_rem   <= w_acc_amt;
            r_id    <= w_grant1;
            r_state <= (w_acc_amt == 4'd0) ? c_done : c_shift;
          end
        end
        c_shift: begin
          r_work <= w_s3;
          r_rem  <= w_rem_next;
          if (w_rem_next == 4'd0) begin
            r_state <= c_done;
          end
        end
        c_done: begin
          // Returning to IDLE here means the next accept is one cycle later.
          if (res_ready) begin
            r_state <= c_idle;
            r_ptr   <= ~r_id;
          end
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign res_valid  = (r_state == c_done);
  assign res_data   = r_work;
  assign res_id     = r_id;
  assign busy       = ~w_idle;

endmodule

`default_nettype wire

// File: tb/tb_barrel_shift_sequencer.sv
// ============================================================================
//  Module      : tb_barrel_shift_sequencer
//  Description : Self-checking bench for barrel_shift_sequencer with a
//                behavioural shift/latency/arbitration reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_barrel_shift_sequencer;

  localparam int PM = 7;

  logic       clk;
  logic       rst;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic [3:0] req0_amt;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic [3:0] req1_amt;
  logic       req1_ready;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_id;
  logic       res_ready;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  barrel_shift_sequencer #(.PASS_MAX(PM)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference: shift in wide arithmetic and truncate.
  function automatic logic [7:0] exp_res(input logic [7:0] d, input logic [3:0] a);
    logic [15:0] t;
    t = {8'h00, d} << a;
    return t[7:0];
  endfunction

  function automatic int exp_lat(input logic [3:0] a);
    int ai;
    ai = int'(a);
    return (ai == 0) ? 1 : 1 + (ai + PM - 1) / PM;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one job with res_ready high; measures, does not judge.
  task automatic do_job(input bit id, input logic [7:0] d, input logic [3:0] a, input bit noise,
                        output int lat, output logic [7:0] rd, output logic rid,
                        output int nbusy, output logic got_ready);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!id) begin
      req0_valid = 1'b1; req0_data = d; req0_amt = a;
    end else begin
      req1_valid = 1'b1; req1_data = d; req1_amt = a;
    end
    #1;
    got_ready = id ? req1_ready : req0_ready;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 1; nbusy = 0; rd = 8'h00; rid = 1'b0;
    while (lat < 40) begin
      if (busy) nbusy++;
      if (res_valid) begin
        rd = res_data;
        rid = res_id;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        break;
      end
      if (noise) begin
        req0_valid = 1'($urandom_range(0, 1)); req0_data = 8'($urandom); req0_amt = 4'($urandom);
        req1_valid = 1'($urandom_range(0, 1)); req1_data = 8'($urandom); req1_amt = 4'($urandom);
      end
      tick();
      lat++;
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({res_valid, res_data, res_id, busy} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%0b data=%02h id=%0b busy=%0b, want all 0", res_valid, res_data, res_id, busy);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if ({res_valid, busy, req0_ready, req1_ready} !== 4'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got valid=%0b busy=%0b r0=%0b r1=%0b, want 0", res_valid, busy, req0_ready, req1_ready);
    end
  endtask

  task automatic test_single();
    int lat, nb; logic [7:0] rd; logic rid, gr;
    do_job(1'b0, 8'h0F, 4'd1, 1'b0, lat, rd, rid, nb, gr);
    n_tests++;
    if (gr !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %0b want 1", gr); end
    n_tests++;
    if (lat !== 2) begin n_fail++; $display("FAIL single_latency: got %0d want 2", lat); end
    n_tests++;
    if (rd !== 8'h1E || rid !== 1'b0) begin n_fail++; $display("FAIL single_result: got %02h/%0b want 1e/0", rd, rid); end
  endtask

  task automatic test_seq();
    int lat, nb; logic [7:0] rd; logic rid, gr;
    do_job(1'b0, 8'h0F, 4'd3, 1'b0, lat, rd, rid, nb, gr);
    n_tests++;
    if (rd !== 8'h78) begin n_fail++; $display("FAIL seq_amt3: got %02h want 78", rd); end
    do_job(1'b0, 8'h0F, 4'd4, 1'b0, lat, rd, rid, nb, gr);
    n_tests++;
    if (rd !== 8'hF0) begin n_fail++; $display("FAIL seq_amt4: got %02h want f0", rd); end
  endtask

  task automatic test_amt15();
    int lat, nb; logic [7:0] rd; logic rid, gr;
    do_job(1'b1, 8'hFF, 4'd15, 1'b0, lat, rd, rid, nb, gr);
    n_tests++;
    if (lat !== 4) begin n_fail++; $display("FAIL amt15_latency: got %0d want 4", lat); end
    n_tests++;
    if (rd !== 8'h00 || rid !== 1'b1) begin n_fail++; $display("FAIL amt15_result: got %02h/%0b want 00/1", rd, rid); end
    n_tests++;
    if (nb !== 4) begin n_fail++; $display("FAIL amt15_busy: got %0d cycles want 4", nb); end
  endtask

  task automatic test_arbitration();
    logic exp_ptr, served, in_done;
    logic [7:0] d0, d1, exp_d;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    d0 = 8'($urandom); d1 = 8'($urandom);
    exp_ptr = 1'b0; in_done = 1'b0; served = 1'b0; exp_d = 8'h00;
    req0_valid = 1'b1; req0_data = d0; req0_amt = 4'd0;
    req1_valid = 1'b1; req1_data = d1; req1_amt = 4'd0;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (!in_done) begin
        n_tests++;
        if (req0_ready !== (exp_ptr == 1'b0) || req1_ready !== (exp_ptr == 1'b1)) begin
          n_fail++;
          $display("FAIL arb_grant[%0d]: got r0=%0b r1=%0b want favoured=%0d", i, req0_ready, req1_ready, exp_ptr);
        end
        served = exp_ptr;
        exp_d = served ? d1 : d0;
        in_done = 1'b1;
      end else begin
        n_tests++;
        if (res_valid !== 1'b1 || res_id !== served || res_data !== exp_d || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL arb_result[%0d]: got v=%0b id=%0b d=%02h r0=%0b r1=%0b want v=1 id=%0b d=%02h r=0",
                   i, res_valid, res_id, res_data, req0_ready, req1_ready, served, exp_d);
        end
        exp_ptr = ~served;
        in_done = 1'b0;
      end
      tick();
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] d, exp_d;
    logic [3:0] a;
    d = 8'($urandom); a = 4'($urandom);
    exp_d = exp_res(d, a);
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_data = d; req0_amt = a;
    #1;
    tick();
    req0_valid = 1'b0;
    for (int k = 0; k < 20 && !res_valid; k++) tick();
    n_tests++;
    if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_wait: res_valid never rose, got %0b want 1", res_valid); end
    for (int k = 0; k < 5; k++) begin
      req0_valid = 1'b1; req0_data = 8'($urandom); req0_amt = 4'($urandom);
      req1_valid = 1'b1; req1_data = 8'($urandom); req1_amt = 4'($urandom);
      #1;
      n_tests++;
      if (res_valid !== 1'b1 || res_data !== exp_d || res_id !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%0b d=%02h id=%0b r0=%0b r1=%0b want v=1 d=%02h id=0 r=0",
                 k, res_valid, res_data, res_id, req0_ready, req1_ready, exp_d);
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    n_tests++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_release: got v=%0b busy=%0b want 0/0", res_valid, busy); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    bit seen;
    res_ready = 1'b1;
    req1_valid = 1'b1; req1_data = 8'hFF; req1_amt = 4'd15;
    #1;
    tick();
    req1_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if ({res_valid, res_data, res_id, busy, req0_ready, req1_ready} !== 13'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got v=%0b d=%02h id=%0b busy=%0b r0=%0b r1=%0b want all 0",
               res_valid, res_data, res_id, busy, req0_ready, req1_ready);
    end
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (res_valid) seen = 1'b1;
      tick();
    end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_result: got res_valid after abort, want none"); end
    d = 8'($urandom);
    req0_valid = 1'b1; req0_data = d;            req0_amt = 4'd2;
    req1_valid = 1'b1; req1_data = 8'($urandom); req1_amt = 4'd2;
    #1;
    n_tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_first_grant: got r0=%0b r1=%0b want 1/0", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int k = 0; k < 20 && !res_valid; k++) tick();
    n_tests++;
    if (res_valid !== 1'b1 || res_id !== 1'b0 || res_data !== exp_res(d, 4'd2)) begin
      n_fail++;
      $display("FAIL rst_mid_job: got v=%0b id=%0b d=%02h want 1/0/%02h", res_valid, res_id, res_data, exp_res(d, 4'd2));
    end
    tick();
  endtask

  task automatic test_random();
    int lat, nb;
    logic [7:0] rd, d;
    logic [3:0] a;
    logic rid, gr;
    bit id;
    res_ready = 1'b1;
    for (int j = 0; j < 30; j++) begin
      id = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      a  = (j < 16) ? 4'(j) : 4'($urandom);
      do_job(id, d, a, 1'b1, lat, rd, rid, nb, gr);
      n_tests++;
      if (gr !== 1'b1 || lat !== exp_lat(a) || nb !== exp_lat(a) || rd !== exp_res(d, a) || rid !== id) begin
        n_fail++;
        $display("FAIL rand_job[%0d] id=%0b d=%02h a=%0d: got ready=%0b lat=%0d busy=%0d res=%02h rid=%0b want ready=1 lat=%0d busy=%0d res=%02h rid=%0b",
                 j, id, d, a, gr, lat, nb, rd, rid, exp_lat(a), exp_lat(a), exp_res(d, a), id);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    req0_valid = 1'b0; req0_data = 8'h00; req0_amt = 4'd0;
    req1_valid = 1'b0; req1_data = 8'h00; req1_amt = 4'd0;
    res_ready = 1'b1;
    test_reset();
    test_single();
    test_seq();
    test_amt15();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
